// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter_if
//  Description : Bundles the two requester command/response channels, the
//                single data-memory channel and the busy flag of the
//                dmem_arbiter.
//                  slave  : arbiter side (takes commands, drives memory)
//                  master : environment side (requesters + memory)
//  Signals     : rN_req/addr/data/width/we/sext  command from requester N
//                rN_gnt/rvalid/rdata/err         response to requester N
//                m_addr/data/width/memwrite/sign_extend  memory command
//                m_result                        combinational memory data
//                busy                            arbiter in ACCESS
//  Revision    : 1.0  initial release
// ============================================================================
interface dmem_arbiter_if;
  // requester 0
  logic        r0_req;
  logic [31:0] r0_addr;
  logic [31:0] r0_data;
  logic [1:0]  r0_width;
  logic        r0_we;
  logic        r0_sext;
  logic        r0_gnt;
  logic        r0_rvalid;
  logic [31:0] r0_rdata;
  logic        r0_err;
  // requester 1
  logic        r1_req;
  logic [31:0] r1_addr;
  logic [31:0] r1_data;
  logic [1:0]  r1_width;
  logic        r1_we;
  logic        r1_sext;
  logic        r1_gnt;
  logic        r1_rvalid;
  logic [31:0] r1_rdata;
  logic        r1_err;
  // memory side
  logic [31:0] m_addr;
  logic [31:0] m_data;
  logic [1:0]  m_width;
  logic        m_memwrite;
  logic        m_sign_extend;
  logic [31:0] m_result;
  // status
  logic        busy;

  modport slave (
    input  r0_req, r0_addr, r0_data, r0_width, r0_we, r0_sext,
    output r0_gnt, r0_rvalid, r0_rdata, r0_err,
    input  r1_req, r1_addr, r1_data, r1_width, r1_we, r1_sext,
    output r1_gnt, r1_rvalid, r1_rdata, r1_err,
    output m_addr, m_data, m_width, m_memwrite, m_sign_extend,
    input  m_result,
    output busy
  );

  modport master (
    output r0_req, r0_addr, r0_data, r0_width, r0_we, r0_sext,
    input  r0_gnt, r0_rvalid, r0_rdata, r0_err,
    output r1_req, r1_addr, r1_data, r1_width, r1_we, r1_sext,
    input  r1_gnt, r1_rvalid, r1_rdata, r1_err,
    input  m_addr, m_data, m_width, m_memwrite, m_sign_extend,
    output m_result,
    input  busy
  );
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-requester arbiter in front of a single data memory.
//                IDLE grants one request combinationally and latches its
//                command; ACCESS drives the memory for one cycle and captures
//                the result; the response (rvalid/err/rdata) appears the
//                cycle after ACCESS. Accesses with addr+size > ADDR_LIMIT are
//                rejected with err=1, no write and rdata=0.
//  Ports       : clk  - clock, all state updates on posedge
//                rst  - synchronous active-high reset
//                bus  - dmem_arbiter_if.slave (requesters, memory, busy)
//  Parameters  : ADDR_LIMIT - byte-address bound (default 4096)
//  Options     : DMEM_ARB_RR_EN defined   -> round-robin on conflict
//                DMEM_ARB_RR_EN undefined -> fixed priority, r0 wins
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter #(
  parameter int unsigned ADDR_LIMIT = 4096
) (
  input  wire logic           clk,
  input  wire logic           rst,
  dmem_arbiter_if.slave       bus
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } state_e;

  localparam logic [1:0]  c_W_BYTE  = 2'b00;
  localparam logic [1:0]  c_W_HALF  = 2'b01;
  localparam logic [1:0]  c_W_WORD  = 2'b10;
  localparam logic [1:0]  c_W_NOP   = 2'b11;
  localparam logic [32:0] c_LIMIT   = 33'(ADDR_LIMIT);

  state_e      state_q, state_d;

  // latched command of the granted requester
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [1:0]  width_q;
  logic        we_q;
  logic        sext_q;
  logic        id_q;

  // per-requester response registers
  logic [31:0] rdata_q [2];
  logic [1:0]  rvalid_q;
  logic [1:0]  err_q;

  logic        req_any;
  logic        win_id;     // requester chosen this cycle (valid when req_any)
  logic        grant;      // a grant is actually issued this cycle
  logic [2:0]  size;
  logic [32:0] end_addr;
  logic        range_err;

  assign req_any = bus.r0_req | bus.r1_req;

`ifdef DMEM_ARB_RR_EN
  // Points at the requester that wins the next conflict.
  logic ptr_q;

  always_comb begin
    if (bus.r0_req && bus.r1_req) begin
      win_id = ptr_q;
    end else begin
      win_id = ~bus.r0_req;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= 1'b0;
    end else if (grant) begin
      ptr_q <= ~win_id;
    end
  end
`else
  // Fixed priority: r0 whenever it asks.
  always_comb begin
    win_id = ~bus.r0_req;
  end
`endif

  assign grant = (state_q == ST_IDLE) && !rst && req_any;

  // Range check on the latched command; the compare is done on 33 bits so
  // addresses near 2^32 cannot wrap into range. No-op width never errors.
  always_comb begin
    size = 3'd0;
    case (width_q)
      c_W_BYTE: size = 3'd1;
      c_W_HALF: size = 3'd2;
      c_W_WORD: size = 3'd4;
      default:  size = 3'd0;
    endcase
  end

  assign end_addr  = {1'b0, addr_q} + {30'd0, size};
  assign range_err = (width_q != c_W_NOP) && (end_addr > c_LIMIT);

  // Next state, grants and memory-side outputs.
  always_comb begin
    state_d           = state_q;
    bus.r0_gnt        = 1'b0;
    bus.r1_gnt        = 1'b0;
    bus.m_addr        = 32'd0;
    bus.m_data        = 32'd0;
    bus.m_width       = 2'b00;
    bus.m_memwrite    = 1'b0;
    bus.m_sign_extend = 1'b0;
    bus.busy          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant) begin
          bus.r0_gnt = ~win_id;
          bus.r1_gnt = win_id;
          state_d    = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.busy          = 1'b1;
        bus.m_addr        = addr_q;
        bus.m_data        = data_q;
        bus.m_width       = width_q;
        bus.m_sign_extend = sext_q;
        // rst is checked combinationally so a reset landing in ACCESS
        // blocks the write that would otherwise commit on this edge.
        bus.m_memwrite    = we_q && (width_q != c_W_NOP) && !range_err && !rst;
        state_d           = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, command latch and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= 32'd0;
      data_q     <= 32'd0;
      width_q    <= 2'b00;
      we_q       <= 1'b0;
      sext_q     <= 1'b0;
      id_q       <= 1'b0;
      rdata_q[0] <= 32'd0;
      rdata_q[1] <= 32'd0;
      rvalid_q   <= 2'b00;
      err_q      <= 2'b00;
    end else begin
      state_q  <= state_d;
      rvalid_q <= 2'b00;
      err_q    <= 2'b00;

      if (grant) begin
        id_q <= win_id;
        if (win_id) begin
          addr_q  <= bus.r1_addr;
          data_q  <= bus.r1_data;
          width_q <= bus.r1_width;
          we_q    <= bus.r1_we;
          sext_q  <= bus.r1_sext;
        end else begin
          addr_q  <= bus.r0_addr;
          data_q  <= bus.r0_data;
          width_q <= bus.r0_width;
          we_q    <= bus.r0_we;
          sext_q  <= bus.r0_sext;
        end
      end

      if (state_q == ST_ACCESS) begin
        rvalid_q[id_q] <= 1'b1;
        err_q[id_q]    <= range_err;
        // Rejected accesses return zero; good writes leave rdata alone.
        if (range_err) begin
          rdata_q[id_q] <= 32'd0;
        end else if (!we_q) begin
          rdata_q[id_q] <= bus.m_result;
        end
      end
    end
  end

  assign bus.r0_rvalid = rvalid_q[0];
  assign bus.r1_rvalid = rvalid_q[1];
  assign bus.r0_err    = err_q[0];
  assign bus.r1_err    = err_q[1];
  assign bus.r0_rdata  = rdata_q[0];
  assign bus.r1_rdata  = rdata_q[1];

endmodule
`default_nettype wire
